// File: rtl/spi_instr_fetch.sv
// -----------------------------------------------------------------------------
// spi_instr_fetch
//
// Fetches one 12-bit instruction (4-bit opcode + 8-bit operand) from an
// external SPI RAM per request. Each fetch is a single mode-0 SPI frame of
// 40 bits with chip select held low the whole time:
//   CMD_READ (8) | ADDR_HI (4) | req_addr (12) | data byte 0 (8) | data byte 1 (8)
// The opcode is the low nibble of data byte 0. The operand is data byte 1.
//
// Ports
//   clk, rst_n        single rising-edge clock, synchronous active-low reset
//   req_valid/ready   fetch request handshake, carrying req_addr (12 bit PC)
//   instr_valid/ready instruction handshake, carrying instr_opcode/operand
//   busy              high while an SPI frame is in progress
//   spi_cs_n, spi_sck, spi_mosi, spi_miso  SPI mode-0 master pins
//
// Build option
//   SPI_INSTR_FETCH_SLOW_SCK_EN  when defined, each SCK phase lasts 2 clk
//                                (4 clk per bit, 162 clk latency) instead of
//                                1 clk (2 clk per bit, 82 clk latency).
// -----------------------------------------------------------------------------
module spi_instr_fetch #(
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter logic [3:0] ADDR_HI  = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [11:0] req_addr,
    output logic        req_ready,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [3:0]  instr_opcode,
    output logic [7:0]  instr_operand,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        OUTPUT
    } state_e;

    localparam logic [5:0] LAST_BIT  = 6'd39;
    localparam logic [5:0] FIRST_RX  = 6'd24;

    state_e      state_q, state_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        valid_q, valid_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [7:0]  operand_q, operand_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        phase_end;

`ifdef SPI_INSTR_FETCH_SLOW_SCK_EN
    // Each SCK phase is two clk long: the first clk of a phase only arms div_q.
    logic div_q, div_d;
    assign phase_end = div_q;
`else
    assign phase_end = 1'b1;
`endif

    assign req_ready     = (state_q == IDLE) && !valid_q;
    assign busy          = (state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD);
    assign instr_valid   = valid_q;
    assign instr_opcode  = opcode_q;
    assign instr_operand = operand_q;
    assign spi_cs_n      = cs_n_q;
    assign spi_sck       = sck_q;
    assign spi_mosi      = mosi_q;

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
`ifdef SPI_INSTR_FETCH_SLOW_SCK_EN
        div_d     = div_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    tx_d    = {CMD_READ, ADDR_HI, req_addr};
                    cs_n_d  = 1'b0;
                    state_d = CS_SETUP;
                end
            end

            CS_SETUP: begin
                // First edge of bit 0: present the command MSB with SCK low.
                mosi_d    = tx_q[23];
                tx_d      = {tx_q[22:0], 1'b0};
                sck_d     = 1'b0;
                bit_cnt_d = '0;
`ifdef SPI_INSTR_FETCH_SLOW_SCK_EN
                div_d     = 1'b0;
`endif
                state_d   = SHIFT;
            end

            SHIFT: begin
`ifdef SPI_INSTR_FETCH_SLOW_SCK_EN
                div_d = !div_q;
`endif
                if (phase_end) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // Falling SCK ends the current bit: sample data bits
                        // here and present the next MOSI bit in the same edge.
                        sck_d = 1'b0;
                        if (bit_cnt_q >= FIRST_RX) begin
                            rx_d = {rx_q[14:0], spi_miso};
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            mosi_d  = 1'b0;
                            state_d = CS_HOLD;
                        end else begin
                            // tx_q has been shifted empty after 24 bits, so the
                            // data phase drives zeros on MOSI.
                            mosi_d    = tx_q[23];
                            tx_d      = {tx_q[22:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
            end

            CS_HOLD: begin
                cs_n_d    = 1'b1;
                valid_d   = 1'b1;
                opcode_d  = rx_q[11:8];
                operand_d = rx_q[7:0];
                state_d   = OUTPUT;
            end

            OUTPUT: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: synchronous reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!rst_n) begin
            state_q   <= IDLE;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            operand_q <= '0;
            bit_cnt_q <= '0;
`ifdef SPI_INSTR_FETCH_SLOW_SCK_EN
            div_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef SPI_INSTR_FETCH_SLOW_SCK_EN
            div_q     <= div_d;
`endif
        end
    end

    // NOTE: the shift registers carry no reset: tx_q is loaded on acceptance and
    // rx_q is completely refilled before it is ever copied to the outputs.
    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
    end

endmodule

// File: tb/tb_spi_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_spi_instr_fetch
//
// Self-checking bench for spi_instr_fetch. A behavioural SPI RAM answers each
// frame from a byte array, a recorder pushes the expected instruction into a
// scoreboard queue whenever a request is accepted, and a monitor pops and
// compares when instr_valid rises. Directed cases cover reset, a long stall,
// a mid-frame reset abort, the top address and back-to-back fetches. A
// randomized phase follows.
// -----------------------------------------------------------------------------
module tb_spi_instr_fetch;

`ifdef SPI_INSTR_FETCH_SLOW_SCK_EN
    localparam int LATENCY    = 162;
    localparam int SCK_PERIOD = 4;
`else
    localparam int LATENCY    = 82;
    localparam int SCK_PERIOD = 2;
`endif
    localparam logic [7:0] CMD = 8'h03;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [11:0] req_addr;
    logic        req_ready;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_opcode;
    logic [7:0]  instr_operand;
    logic        busy;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    spi_instr_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_operand(instr_operand),
        .busy         (busy),
        .spi_cs_n     (spi_cs_n),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- models
    logic [7:0] ram [0:4096];

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  opcode;
        logic [7:0]  operand;
        int          idx;
    } exp_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] addr;
    } frame_t;

    exp_t   exp_q[$];
    frame_t frame_q[$];

    int cyc      = 0;
    int last_hs  = -100;
    int accepts  = 0;
    bit b2b      = 1'b0;

    // Edge recorder: cyc is the index of the edge just taken.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n && req_valid && req_ready) begin
            e.addr    = {4'h0, req_addr};
            e.opcode  = ram[req_addr][3:0];
            e.operand = ram[int'(req_addr) + 1];
            e.idx     = cyc;
            exp_q.push_back(e);
            accepts++;
            if (b2b) check("b2b_start_gap", cyc - last_hs, 1);
        end
        if (rst_n && instr_valid && instr_ready) last_hs = cyc;
    end

    // SPI RAM slave: counts SCK rises within a frame.
    int          sk = 0;
    logic [39:0] rx_frame;
    logic [15:0] sdata;
    int          last_rise;

    initial begin
        frame_t f;
        logic [15:0] a;
        forever begin
            @(negedge spi_cs_n);
            sk = 0;
            forever begin
                @(posedge spi_sck or posedge spi_cs_n);
                if (spi_cs_n) break;
                if (sk > 0) check("sck_period", cyc - last_rise, SCK_PERIOD);
                last_rise = cyc;
                if (sk < 24) rx_frame[39 - sk] = spi_mosi;
                else check("mosi_zero_in_data", spi_mosi, 0);
                if (sk == 23) begin
                    a     = rx_frame[31:16];
                    sdata = {ram[int'(a) % 4097], ram[(int'(a) + 1) % 4097]};
                end
                sk++;
            end
            if (sk == 40) begin
                f.cmd  = rx_frame[39:32];
                f.addr = rx_frame[31:16];
                frame_q.push_back(f);
            end
        end
    end

    // MISO: data bit k is presented after the k-th SCK rise; otherwise noise.
    initial spi_miso = 1'b0;
    always @(negedge clk) begin
        if (!spi_cs_n && sk > 24) spi_miso = sdata[40 - sk];
        else spi_miso = 1'($urandom_range(0, 1));
    end

    // ---------------------------------------------------------------- monitor
    logic       prev_valid = 1'b0;
    logic [3:0] held_op;
    logic [7:0] held_opd;
    int         cs_high = 0;

    always @(negedge clk) begin
        exp_t   e;
        frame_t f;
        if (rst_n) begin
            check("sck_low_when_cs_high", spi_cs_n && spi_sck, 0);
            check("busy_vs_cs", busy, !spi_cs_n);
            check("req_ready_rule", req_ready, !busy && !instr_valid);

            if (instr_valid && !prev_valid) begin
                if (exp_q.size() == 0 || frame_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got valid with %0d expected, %0d frames",
                             exp_q.size(), frame_q.size());
                end else begin
                    e = exp_q.pop_front();
                    f = frame_q.pop_front();
                    check("latency", cyc - e.idx, LATENCY);
                    check("opcode", instr_opcode, e.opcode);
                    check("operand", instr_operand, e.operand);
                    check("frame_cmd", f.cmd, CMD);
                    check("frame_addr", f.addr, e.addr);
                    held_op  = e.opcode;
                    held_opd = e.operand;
                end
            end else if (instr_valid) begin
                check("output_stable", {instr_opcode, instr_operand}, {held_op, held_opd});
            end

            if (last_hs == cyc) begin
                check("valid_clear_after_hs", instr_valid, 0);
                check("req_ready_after_hs", req_ready, 1);
            end

            if (spi_cs_n) cs_high++;
            else begin
                if (cs_high > 0) check("cs_high_gap_ge2", cs_high >= 2, 1);
                cs_high = 0;
            end
        end
        prev_valid = instr_valid;
    end

    // ---------------------------------------------------------------- tasks
    task automatic fetch(input logic [11:0] a);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got req_ready=0, expected 1 within 2000 cycles");
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 12'($urandom);
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!instr_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("instr_valid_timeout", instr_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        instr_ready = 1'b1;
        while ((exp_q.size() != 0 || instr_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------------------------------------------------------- stimulus
    bit done = 1'b0;

    initial begin
        bit saw;
        int start;
        int n;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        instr_ready = 1'b0;
        for (int i = 0; i < 4097; i++) ram[i] = 8'($urandom);
        ram[5] = 8'hA3;
        ram[6] = 8'h5C;
        ram[1] = 8'hF7;
        ram[2] = 8'h12;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_opcode", instr_opcode, 0);
        check("rst_operand", instr_operand, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_rst", req_ready, 1);

        // Fetch 0x005 and stall the consumer for 10 cycles.
        fetch(12'h005);
        wait_valid(400);
        check("dir_opcode_005", instr_opcode, 4'h3);
        check("dir_operand_005", instr_operand, 8'h5C);
        repeat (10) begin
            @(negedge clk);
            check("stall_valid", instr_valid, 1);
            check("stall_req_ready", req_ready, 0);
            check("stall_busy", busy, 0);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("pulse_valid_clear", instr_valid, 0);
        check("pulse_req_ready", req_ready, 1);

        // Reset abort at bit 30 of a frame.
        fetch(12'($urandom));
        n = 0;
        while (!(sk >= 31 && !spi_cs_n) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reached_bit30", sk >= 31, 1);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_cs_n", spi_cs_n, 1);
        check("abort_sck", spi_sck, 0);
        check("abort_valid", instr_valid, 0);
        check("abort_busy", busy, 0);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        saw = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (instr_valid) saw = 1'b1;
        end
        check("no_valid_after_abort", saw, 0);

        // Top address and the other directed pattern.
        fetch(12'hFFF);
        drain();
        fetch(12'h001);
        wait_valid(400);
        check("dir_opcode_001", instr_opcode, 4'h7);
        check("dir_operand_001", instr_operand, 8'h12);
        drain();

        // Back-to-back with req_valid held and instr_ready tied high.
        instr_ready = 1'b1;
        req_valid   = 1'b1;
        start = accepts;
        n = 0;
        while (accepts < start + 5 && n < 2000) begin
            @(negedge clk);
            req_addr = 12'($urandom);
            if (accepts > start) b2b = 1'b1;
            n++;
        end
        check("b2b_accepts", accepts - start, 5);
        req_valid = 1'b0;
        b2b = 1'b0;
        drain();

        // Randomized fetches with random consumer stalls.
        fork
            begin
                repeat (12) begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    fetch(12'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    instr_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        check("frames_consumed", frame_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
